// File: rtl/cache_write_buffer_if.sv
// ============================================================================
//  Module      : cache_write_buffer_if
//  Description : Bus bundle for the cache write buffer: store intake, load
//                forwarding lookup, memory drain port and occupancy status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_write_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_valid_i;
    logic [WIDTH-1:0]  wr_addr_i;
    logic [WIDTH-1:0]  wr_data_i;
    logic              wr_byte_op_i;
    logic              wr_ready_o;
    logic [WIDTH-1:0]  ld_addr_i;
    logic              fwd_hit_o;
    logic [WIDTH-1:0]  fwd_data_o;
    logic              fwd_stall_o;
    logic [WIDTH-1:0]  mem_address_o;
    logic [WIDTH-1:0]  mem_write_data_o;
    logic              mem_write_enable_o;
    logic              mem_byte_op_o;
    logic              mem_ack_i;
    logic              empty_o;
    logic              full_o;
    logic [CNT_W-1:0]  count_o;

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, wr_byte_op_i, ld_addr_i, mem_ack_i,
        output wr_ready_o, fwd_hit_o, fwd_data_o, fwd_stall_o,
               mem_address_o, mem_write_data_o, mem_write_enable_o, mem_byte_op_o,
               empty_o, full_o, count_o
    );

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, wr_byte_op_i, ld_addr_i, mem_ack_i,
        input  wr_ready_o, fwd_hit_o, fwd_data_o, fwd_stall_o,
               mem_address_o, mem_write_data_o, mem_write_enable_o, mem_byte_op_o,
               empty_o, full_o, count_o
    );
endinterface

`default_nettype wire

// File: rtl/cache_write_buffer.sv
// ============================================================================
//  Module      : cache_write_buffer
//  Description : FIFO store buffer between the data cache and memory with
//                store-to-load forwarding. WB_COALESCE_EN enables in-place
//                merging of word stores into the youngest pending entry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_write_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cache_write_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

    logic [WIDTH-1:0] r_addr [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_byte;
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    state_t           r_state;

    logic             w_push;
    logic             w_pop;
    logic             w_coalesce;
    logic [PTR_W-1:0] w_tail_m1;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_issue;

    assign w_issue   = (r_state == ST_ISSUE);
    assign w_tail_m1 = r_tail - 1'b1;

`ifdef WB_COALESCE_EN
    // Youngest entry sits just behind tail; the head being issued must not change under memory.
    assign w_coalesce = bus.wr_valid_i && !bus.wr_byte_op_i && !r_empty
                        && r_valid[w_tail_m1] && !r_byte[w_tail_m1]
                        && (r_addr[w_tail_m1][WIDTH-1:2] == bus.wr_addr_i[WIDTH-1:2])
                        && !(w_issue && (w_tail_m1 == r_head));
`else
    assign w_coalesce = 1'b0;
`endif

    assign bus.wr_ready_o = !r_full || w_coalesce;
    assign w_push         = bus.wr_valid_i && !r_full && !w_coalesce;
    assign w_pop          = w_issue && bus.mem_ack_i;
    assign w_count_nxt    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_state <= ST_IDLE;
        end else begin
            if (w_push) begin
                r_addr[r_tail]  <= bus.wr_addr_i;
                r_data[r_tail]  <= bus.wr_data_i;
                r_byte[r_tail]  <= bus.wr_byte_op_i;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_coalesce) begin
                r_data[w_tail_m1] <= bus.wr_data_i;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            case (r_state)
                ST_IDLE:  if (r_count != '0) r_state <= ST_ISSUE;
                ST_ISSUE: if (w_pop && (w_count_nxt == '0)) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_write_enable_o = w_issue;
    assign bus.mem_address_o      = w_issue ? r_addr[r_head] : '0;
    assign bus.mem_write_data_o   = w_issue ? r_data[r_head] : '0;
    assign bus.mem_byte_op_o      = w_issue && r_byte[r_head];
    assign bus.count_o            = r_count;
    assign bus.full_o             = r_full;
    assign bus.empty_o            = r_empty;

    logic             w_found;
    logic             w_any_byte;
    logic [PTR_W-1:0] w_young;
    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        w_found    = 1'b0;
        w_any_byte = 1'b0;
        w_young    = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (r_valid[w_idx] && (r_addr[w_idx][WIDTH-1:2] == bus.ld_addr_i[WIDTH-1:2])) begin
                w_found = 1'b1;
                w_young = w_idx;
                if (r_byte[w_idx]) w_any_byte = 1'b1;
            end
        end
    end

    assign bus.fwd_stall_o = w_any_byte;
    assign bus.fwd_hit_o   = w_found && !w_any_byte;
    assign bus.fwd_data_o  = (w_found && !w_any_byte) ? r_data[w_young] : '0;

    logic w_unused_ld;
    assign w_unused_ld = ^bus.ld_addr_i[1:0];

endmodule

`default_nettype wire
